// File: rtl/bsg_wormhole_inject_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bsg_wormhole_inject_arbiter
// Description : Round-robin, packet-atomic arbiter sharing one wormhole
//               router injection port among several local requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_wormhole_inject_arbiter #(
  parameter int flit_width_p = 32,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 8,
  parameter int num_req_p    = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [num_req_p*flit_width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]            req_v_i,
  output logic [num_req_p-1:0]            req_ready_and_o,
  output logic [flit_width_p-1:0]         data_o,
  output logic                            v_o,
  input  logic                            ready_and_i,
  output logic                            busy_o,
  output logic [$clog2(num_req_p)-1:0]    owner_o
);

  localparam int ID_W = $clog2(num_req_p);

  localparam logic [0:0] C_IDLE = 1'b0;
  localparam logic [0:0] C_BUSY = 1'b1;

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [len_width_p-1:0] r_cnt;
  logic [len_width_p-1:0] w_cnt_nxt;
  logic [ID_W-1:0]      r_owner;
  logic [ID_W-1:0]      w_owner_nxt;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [ID_W-1:0]      w_rr_ptr_nxt;

  logic [ID_W-1:0]      w_rr_sel;
  logic [ID_W-1:0]      w_cand;
  logic                 w_rr_found;
  logic [ID_W-1:0]      w_sel;
  logic                 w_active;
  logic                 w_valid;
  logic                 w_hs;
  logic [len_width_p-1:0] w_len;

  // Lowest offset from rr_ptr wins, so scan offsets from high to low.
  always_comb begin
    w_rr_sel   = r_rr_ptr;
    w_cand     = r_rr_ptr;
    w_rr_found = 1'b0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      w_cand = ID_W'((int'(r_rr_ptr) + k) % num_req_p);
      if (req_v_i[w_cand]) begin
        w_rr_sel   = w_cand;
        w_rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= C_IDLE;
      r_cnt    <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      C_IDLE: begin
        if (w_hs) begin
          w_rr_ptr_nxt = (int'(w_sel) == num_req_p - 1) ? '0 : w_sel + 1'b1;
          if (w_len != '0) begin
            w_state_nxt = C_BUSY;
            w_cnt_nxt   = w_len;
            w_owner_nxt = w_sel;
          end
        end
      end
      default: begin
        if (w_hs) begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == len_width_p'(1)) begin
            w_state_nxt = C_IDLE;
          end
        end
      end
    endcase
  end

  // Outputs are gated by reset so nothing leaks while reset is held.
  always_comb begin
    w_sel    = (r_state == C_BUSY) ? r_owner : w_rr_sel;
    w_active = reset_n_i & ((r_state == C_BUSY) | w_rr_found);
    w_valid  = w_active & req_v_i[w_sel];
    w_hs     = w_valid & ready_and_i;
    data_o   = req_data_i[int'(w_sel)*flit_width_p +: flit_width_p];
    w_len    = data_o[len_offset_p +: len_width_p];
    v_o      = w_valid;
    req_ready_and_o = '0;
    if (w_active) begin
      req_ready_and_o[w_sel] = ready_and_i;
    end
    busy_o  = (r_state == C_BUSY);
    owner_o = (r_state == C_BUSY) ? r_owner : '0;
  end

endmodule
`default_nettype wire
